perf_monitor: RTL

- Synthesizable performance and completion monitor, downstream of the core's fetch stage.
- Observes the fetch PC, IFQ status and commit strobes; counts cycles, retired instructions and fetch-starved cycles.
- Detects program completion (PC runs past the program window, or fetch goes quiescent) and exposes counters and a done flag to the bench and the debug bus.
- Replaces ad-hoc bench-side counting with one cycle-exact hardware source.

---
 rtl/perf_monitor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/perf_monitor.sv
// Cycle-exact performance/completion monitor sitting behind the fetch stage.
// Optional timeout completion is enabled by defining PERF_MON_TIMEOUT_EN.
module perf_monitor #(
  parameter int                CNT_W         = 32,
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT    = ADDR_W'('h200),
  parameter int                STABLE_THRESH = 6
`ifdef PERF_MON_TIMEOUT_EN
  , parameter int              TIMEOUT_CYCLES = 500
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              ifq_empty,
  input  logic              ifq_rd_en,
  input  logic              commit_valid,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  starve_count,
  output logic              running,
  output logic              done,
  output logic [1:0]        done_reason
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    R_NONE    = 2'b00,
    R_PC      = 2'b01,
    R_IDLE    = 2'b10,
    R_TIMEOUT = 2'b11
  } reason_e;

  // Quiescence counters are 8 bits wide since the threshold is limited to 1..255.
  localparam logic [7:0] THRESH = 8'(STABLE_THRESH);

  state_e            state_q, state_d;
  reason_e           reason_q, reason_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
  logic              prev_vld_q, prev_vld_d;
  logic [7:0]        stable_q, stable_d;
  logic [7:0]        empty_q, empty_d;
  logic              pc_hit, idle_hit, tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  function automatic logic [7:0] thr_inc(input logic [7:0] v);
    return (v < THRESH) ? v + 8'd1 : THRESH;
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    reason_d   = reason_q;
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    starve_d   = starve_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    stable_d   = stable_q;
    pc_hit     = 1'b0;
    idle_hit   = 1'b0;
    tmo_hit    = 1'b0;

    // PC/IFQ tracking runs in every state; stable_cnt holds while fetch is not valid.
    empty_d = ifq_empty ? thr_inc(empty_q) : 8'd0;
    if (fetch_valid) begin
      prev_pc_d  = fetch_pc;
      prev_vld_d = 1'b1;
      stable_d   = (prev_vld_q && (fetch_pc == prev_pc_q)) ? thr_inc(stable_q) : 8'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (fetch_valid) state_d = S_RUN;
      end
      S_RUN: begin
        cycle_d  = sat_inc(cycle_q, 1'b1);
        instr_d  = sat_inc(instr_q, commit_valid);
        starve_d = sat_inc(starve_q, ifq_empty & ~ifq_rd_en);

        pc_hit   = fetch_valid && (fetch_pc >= ADDR_LIMIT);
        idle_hit = (stable_d == THRESH) && (empty_d == THRESH) && (instr_d != '0);
`ifdef PERF_MON_TIMEOUT_EN
        tmo_hit  = (64'(cycle_d) == 64'(TIMEOUT_CYCLES));
`endif
        if (pc_hit) begin
          state_d  = S_DONE;
          reason_d = R_PC;
        end else if (idle_hit) begin
          state_d  = S_DONE;
          reason_d = R_IDLE;
        end else if (tmo_hit) begin
          state_d  = S_DONE;
          reason_d = R_TIMEOUT;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst || clear) begin
      state_q    <= S_IDLE;
      reason_q   <= R_NONE;
      cycle_q    <= '0;
      instr_q    <= '0;
      starve_q   <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      stable_q   <= '0;
      empty_q    <= '0;
    end else begin
      state_q    <= state_d;
      reason_q   <= reason_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      starve_q   <= starve_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      stable_q   <= stable_d;
      empty_q    <= empty_d;
    end
  end

  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;
  assign starve_count = starve_q;
  assign running      = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign done_reason  = reason_q;

endmodule
